// File: rtl/georgios_pkg.sv
// Shared defaults and the register-select type used by the operand router and register file.
package georgios_pkg;

  localparam int unsigned DefW     = 8;
  localparam int unsigned DefSelW  = 4;
  localparam int unsigned DefNregs = 16;

  typedef logic [DefSelW-1:0] sel_t;

endpackage

// File: rtl/reg_file_responder_enb_edge.sv
// Enable history flop with rising-edge detect; one go pulse per enable assertion.
module enb_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic enb,
  output logic go
);

  logic enb_q;
  logic enb_d;

  // Next history value is simply the current enable level.
  always_comb begin
    enb_d = enb;
    go    = enb & ~enb_q;
  end

  // History clears on reset so an enable already high at release counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb_q <= 1'b0;
    end else begin
      enb_q <= enb_d;
    end
  end

endmodule

// File: rtl/reg_file_responder.sv
// Register file answering the router's select/enable strobes: two read ports, one write port.
module reg_file_responder
  import georgios_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned SEL_W = DefSelW,
  parameter int unsigned NREGS = DefNregs
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] x_sel,
  input  logic             x_enb,
  input  logic [SEL_W-1:0] y_sel,
  input  logic             y_enb,
  input  logic [SEL_W-1:0] z_sel,
  input  logic             z_enb,
  input  logic [W-1:0]     z,
  output logic [W-1:0]     x,
  output logic [W-1:0]     y,
  output logic             x_vld,
  output logic             y_vld,
  output logic             z_ack,
  output logic             sel_err
);

  logic go_x, go_y, go_z;
  logic x_in, y_in, z_in;
  logic x_byp, y_byp;

  logic [W-1:0] regs_q [NREGS];
  logic [W-1:0] regs_d [NREGS];
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic         x_vld_q, x_vld_d;
  logic         y_vld_q, y_vld_d;
  logic         z_ack_q, z_ack_d;
  logic         sel_err_q, sel_err_d;

  enb_edge u_edge_x (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (x_enb),
    .go    (go_x)
  );

  enb_edge u_edge_y (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (y_enb),
    .go    (go_y)
  );

  enb_edge u_edge_z (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (z_enb),
    .go    (go_z)
  );

  // Range checks and same-edge write-to-read bypass.
  always_comb begin
    x_in  = 32'(x_sel) < NREGS;
    y_in  = 32'(y_sel) < NREGS;
    z_in  = 32'(z_sel) < NREGS;
    x_byp = go_z && z_in && (z_sel == x_sel);
    y_byp = go_z && z_in && (z_sel == y_sel);
  end

  // Next state for storage, read data and the single-cycle status pulses.
  always_comb begin
    regs_d = regs_q;
    if (go_z && z_in) begin
      regs_d[z_sel] = z;
    end

    x_d = x_q;
    if (go_x) begin
      x_d = !x_in ? '0 : (x_byp ? z : regs_q[x_sel]);
    end

    y_d = y_q;
    if (go_y) begin
      y_d = !y_in ? '0 : (y_byp ? z : regs_q[y_sel]);
    end

    x_vld_d   = go_x;
    y_vld_d   = go_y;
    z_ack_d   = go_z;
    sel_err_d = (go_x && !x_in) || (go_y && !y_in) || (go_z && !z_in);
  end

  // State registers; reset clears every register and drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      x_q       <= '0;
      y_q       <= '0;
      x_vld_q   <= 1'b0;
      y_vld_q   <= 1'b0;
      z_ack_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_vld_q   <= x_vld_d;
      y_vld_q   <= y_vld_d;
      z_ack_q   <= z_ack_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign x_vld   = x_vld_q;
  assign y_vld   = y_vld_q;
  assign z_ack   = z_ack_q;
  assign sel_err = sel_err_q;

endmodule
